// File: rtl/ppfifo_data_checker.sv
// ppfifo_data_checker: drains ping-pong FIFO read buffers and checks that each
// buffer carries an incrementing word pattern starting at 0.
// Counts checked words, drained buffers and mismatches, with a sticky error flag.
// Optional build macro PPFIFO_CHECKER_CAPTURE_EN: capture the data word and the
// expected value of the first mismatch since reset/clear.
module ppfifo_data_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic                  i_rd_rdy,
    output logic                  o_rd_act,
    input  logic [SIZE_WIDTH-1:0] i_rd_size,
    output logic                  o_rd_stb,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_error,
    output logic [31:0]           o_error_count,
    output logic [31:0]           o_word_count,
    output logic [31:0]           o_buffer_count,
    output logic [DATA_WIDTH-1:0] o_bad_data,
    output logic [DATA_WIDTH-1:0] o_bad_expected
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_act_q, rd_act_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] count_q, count_d;
    logic [SIZE_WIDTH-1:0] expected_q, expected_d;
    logic                  error_q, error_d;
    logic [31:0]           error_count_q, error_count_d;
    logic [31:0]           word_count_q, word_count_d;
    logic [31:0]           buffer_count_q, buffer_count_d;

    logic                  pop;
    logic [DATA_WIDTH-1:0] expected_ext;
    logic                  mismatch;

    // Buffer handshake FSM: claim a ready buffer, pop every word, release.
    always_comb begin
        state_d    = state_q;
        rd_act_d   = rd_act_q;
        size_d     = size_q;
        count_d    = count_q;
        expected_d = expected_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable && i_rd_rdy) begin
                    rd_act_d   = 1'b1;
                    size_d     = i_rd_size;
                    count_d    = '0;
                    expected_d = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (count_q < size_q) begin
                    pop        = 1'b1;
                    count_d    = count_q + SIZE_WIDTH'(1);
                    expected_d = expected_q + SIZE_WIDTH'(1);
                end else begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                rd_act_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                rd_act_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign expected_ext = DATA_WIDTH'(expected_q);
    assign mismatch     = pop && (i_rd_data != expected_ext);

    // Statistics update; a clear overrides any event on the same edge.
    always_comb begin
        error_d        = error_q;
        error_count_d  = error_count_q;
        word_count_d   = word_count_q;
        buffer_count_d = buffer_count_q;
        if (i_clear) begin
            error_d        = 1'b0;
            error_count_d  = '0;
            word_count_d   = '0;
            buffer_count_d = '0;
        end else begin
            if (pop) begin
                word_count_d = word_count_q + 32'd1;
            end
            if (mismatch) begin
                error_d = 1'b1;
                if (error_count_q != '1) begin
                    error_count_d = error_count_q + 32'd1;
                end
            end
            if (state_q == RELEASE) begin
                buffer_count_d = buffer_count_q + 32'd1;
            end
        end
    end

    // State, handshake and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_act_q       <= 1'b0;
            size_q         <= '0;
            count_q        <= '0;
            expected_q     <= '0;
            error_q        <= 1'b0;
            error_count_q  <= '0;
            word_count_q   <= '0;
            buffer_count_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_act_q       <= rd_act_d;
            size_q         <= size_d;
            count_q        <= count_d;
            expected_q     <= expected_d;
            error_q        <= error_d;
            error_count_q  <= error_count_d;
            word_count_q   <= word_count_d;
            buffer_count_q <= buffer_count_d;
        end
    end

    assign o_rd_act       = rd_act_q;
    assign o_rd_stb       = pop;
    assign o_error        = error_q;
    assign o_error_count  = error_count_q;
    assign o_word_count   = word_count_q;
    assign o_buffer_count = buffer_count_q;

`ifdef PPFIFO_CHECKER_CAPTURE_EN
    logic [DATA_WIDTH-1:0] bad_data_q, bad_data_d;
    logic [DATA_WIDTH-1:0] bad_expected_q, bad_expected_d;

    // First-mismatch capture: only while the sticky flag is still clear.
    always_comb begin
        bad_data_d     = bad_data_q;
        bad_expected_d = bad_expected_q;
        if (i_clear) begin
            bad_data_d     = '0;
            bad_expected_d = '0;
        end else if (mismatch && !error_q) begin
            bad_data_d     = i_rd_data;
            bad_expected_d = expected_ext;
        end
    end

    // Capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_data_q     <= '0;
            bad_expected_q <= '0;
        end else begin
            bad_data_q     <= bad_data_d;
            bad_expected_q <= bad_expected_d;
        end
    end

    assign o_bad_data     = bad_data_q;
    assign o_bad_expected = bad_expected_q;
`else
    assign o_bad_data     = '0;
    assign o_bad_expected = '0;
`endif

endmodule

// File: tb/tb_ppfifo_data_checker.sv
// Self-checking bench for ppfifo_data_checker: a buffer-level model predicts
// every output each cycle; directed scenarios add hand-computed expectations.
module tb_ppfifo_data_checker;

    localparam int DW = 32;
    localparam int SW = 24;

    logic          clk;
    logic          rst_n;
    logic          i_enable;
    logic          i_clear;
    logic          i_rd_rdy;
    logic          o_rd_act;
    logic [SW-1:0] i_rd_size;
    logic          o_rd_stb;
    logic [DW-1:0] i_rd_data;
    logic          o_error;
    logic [31:0]   o_error_count;
    logic [31:0]   o_word_count;
    logic [31:0]   o_buffer_count;
    logic [DW-1:0] o_bad_data;
    logic [DW-1:0] o_bad_expected;

    ppfifo_data_checker #(
        .DATA_WIDTH(DW),
        .SIZE_WIDTH(SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (i_enable),
        .i_clear       (i_clear),
        .i_rd_rdy      (i_rd_rdy),
        .o_rd_act      (o_rd_act),
        .i_rd_size     (i_rd_size),
        .o_rd_stb      (o_rd_stb),
        .i_rd_data     (i_rd_data),
        .o_error       (o_error),
        .o_error_count (o_error_count),
        .o_word_count  (o_word_count),
        .o_buffer_count(o_buffer_count),
        .o_bad_data    (o_bad_data),
        .o_bad_expected(o_bad_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Words the FIFO presents for the buffer being drained.
    logic [DW-1:0] fifo_words [64];

    // Buffer-level model: a claimed buffer of N words keeps o_rd_act high for
    // N+2 cycles, strobing in the first N of them.
    logic          m_busy     = 1'b0;
    int            m_phase    = 0;
    int            m_size     = 0;
    int            m_pop      = 0;
    logic          m_err      = 1'b0;
    logic [31:0]   m_errcnt   = '0;
    logic [31:0]   m_words    = '0;
    logic [31:0]   m_bufs     = '0;
    logic [DW-1:0] m_bad_data = '0;
    logic [DW-1:0] m_bad_exp  = '0;
    logic          rst_seen   = 1'b0;

    initial forever begin
        @(negedge rst_n);
        rst_seen = 1'b1;
    end

    // Inputs change only at negedge+1, so at a negedge they still hold the
    // values the DUT sampled on the preceding rising edge.
    task automatic model_step();
        logic          pop_now;
        logic [DW-1:0] word;
        logic [DW-1:0] expw;
        logic          mism;
        if (!rst_n || rst_seen) begin
            rst_seen   = 1'b0;
            m_busy     = 1'b0;
            m_phase    = 0;
            m_size     = 0;
            m_pop      = 0;
            m_err      = 1'b0;
            m_errcnt   = '0;
            m_words    = '0;
            m_bufs     = '0;
            m_bad_data = '0;
            m_bad_exp  = '0;
            return;
        end
        pop_now = m_busy && (m_phase <= m_size);
        word    = (m_pop < 64) ? fifo_words[m_pop] : '0;
        expw    = DW'(32'(m_pop) & ((32'd1 << SW) - 32'd1));
        mism    = pop_now && (word != expw);
        if (i_clear) begin
            m_err      = 1'b0;
            m_errcnt   = '0;
            m_words    = '0;
            m_bufs     = '0;
            m_bad_data = '0;
            m_bad_exp  = '0;
        end else begin
            if (pop_now) m_words = m_words + 32'd1;
            if (mism) begin
`ifdef PPFIFO_CHECKER_CAPTURE_EN
                if (!m_err) begin
                    m_bad_data = word;
                    m_bad_exp  = expw;
                end
`endif
                m_err = 1'b1;
                if (m_errcnt != 32'hFFFF_FFFF) m_errcnt = m_errcnt + 32'd1;
            end
            if (m_busy && m_phase == m_size + 2) m_bufs = m_bufs + 32'd1;
        end
        if (pop_now) m_pop++;
        if (m_busy) begin
            if (m_phase == m_size + 2) m_busy = 1'b0;
            else m_phase++;
        end else if (i_enable && i_rd_rdy) begin
            m_busy  = 1'b1;
            m_phase = 1;
            m_size  = int'(i_rd_size);
            m_pop   = 0;
        end
    endtask

    // Per-cycle compare against the model, then present the next FIFO word.
    initial begin
        i_rd_data = '0;
        forever begin
            @(negedge clk);
            model_step();
            check("act",        32'(o_rd_act),  32'(m_busy));
            check("stb",        32'(o_rd_stb),  32'(m_busy && (m_phase <= m_size)));
            check("error",      32'(o_error),   32'(m_err));
            check("error_count", o_error_count, m_errcnt);
            check("word_count",  o_word_count,  m_words);
            check("buffer_count", o_buffer_count, m_bufs);
            check("bad_data",    o_bad_data,    m_bad_data);
            check("bad_expected", o_bad_expected, m_bad_exp);
            i_rd_data = (m_pop < 64) ? fifo_words[m_pop] : '0;
        end
    end

    task automatic fill(input int bad_idx, input logic [DW-1:0] bad_val);
        for (int i = 0; i < 64; i++) fifo_words[i] = DW'(i);
        if (bad_idx >= 0) fifo_words[bad_idx] = bad_val;
    endtask

    task automatic pulse_clear();
        @(negedge clk); #1;
        i_clear = 1'b1;
        @(negedge clk); #1;
        i_clear = 1'b0;
    endtask

    // Offer one buffer and wait until the model sees it released.
    task automatic run_buf(input int size, input int drop_en_after, input int clear_at,
                           input bit keep_rdy, output int act_n);
        int   stb_n;
        int   first_stb;
        int   last_stb;
        bit   started;
        bit   done;
        bit   cleared_prev;
        stb_n        = 0;
        act_n        = 0;
        first_stb    = -1;
        last_stb     = -1;
        started      = 1'b0;
        done         = 1'b0;
        cleared_prev = 1'b0;
        i_rd_size    = SW'(size);
        i_rd_rdy     = 1'b1;
        i_enable     = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk); #1;
            if (cleared_prev) begin
                check("clear_word_count",  o_word_count,  32'd0);
                check("clear_error",       32'(o_error),  32'd0);
                check("clear_error_count", o_error_count, 32'd0);
            end
            if (o_rd_act) act_n++;
            if (o_rd_stb) begin
                stb_n++;
                if (first_stb < 0) first_stb = cyc;
                last_stb = cyc;
            end
            if (m_busy) begin
                started = 1'b1;
                if (!keep_rdy) i_rd_rdy = 1'b0;
            end
            if (started && !m_busy) done = 1'b1;
            if (drop_en_after >= 0 && m_pop >= drop_en_after) i_enable = 1'b0;
            i_clear      = (clear_at >= 0) && m_busy && (m_pop == clear_at) && (m_pop < m_size);
            cleared_prev = i_clear;
        end
        i_clear = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_buf_timeout got=busy exp=released size=%0d", size);
        end
        check("stb_count", 32'(stb_n), 32'(size));
        if (size > 0) check("stb_span", 32'(last_stb - first_stb + 1), 32'(size));
    endtask

    int act_n;

    initial begin
        i_enable  = 1'b0;
        i_clear   = 1'b0;
        i_rd_rdy  = 1'b0;
        i_rd_size = '0;
        rst_n     = 1'b1;
        fill(-1, '0);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_act",        32'(o_rd_act),  32'd0);
        check("rst_stb",        32'(o_rd_stb),  32'd0);
        check("rst_error",      32'(o_error),   32'd0);
        check("rst_error_count", o_error_count, 32'd0);
        check("rst_word_count",  o_word_count,  32'd0);
        check("rst_buffer_count", o_buffer_count, 32'd0);
        rst_n = 1'b1;

        // Two clean 16-word buffers.
        run_buf(16, -1, -1, 1'b0, act_n);
        check("clean1_act_cycles", 32'(act_n), 32'd18);
        run_buf(16, -1, -1, 1'b0, act_n);
        check("clean_error",        32'(o_error),   32'd0);
        check("clean_word_count",   o_word_count,   32'd32);
        check("clean_buffer_count", o_buffer_count, 32'd2);
        check("model_words_pin",    m_words,        32'd32);

        // Injected error at word 5 of an 8-word buffer.
        pulse_clear();
        fill(5, 32'hDEAD_BEEF);
        run_buf(8, -1, -1, 1'b0, act_n);
        check("inj_error",       32'(o_error),  32'd1);
        check("inj_error_count", o_error_count, 32'd1);
        check("inj_word_count",  o_word_count,  32'd8);
`ifdef PPFIFO_CHECKER_CAPTURE_EN
        check("inj_bad_data",     o_bad_data,     32'hDEAD_BEEF);
        check("inj_bad_expected", o_bad_expected, 32'd5);
`else
        check("inj_bad_data",     o_bad_data,     32'd0);
        check("inj_bad_expected", o_bad_expected, 32'd0);
`endif

        // Zero-size buffer.
        pulse_clear();
        fill(-1, '0);
        run_buf(0, -1, -1, 1'b0, act_n);
        check("zero_act_cycles",   32'(act_n),     32'd2);
        check("zero_buffer_count", o_buffer_count, 32'd1);
        check("zero_word_count",   o_word_count,   32'd0);

        // Enable drops after 3 pops of a 10-word buffer; ready stays high.
        pulse_clear();
        run_buf(10, 3, -1, 1'b1, act_n);
        check("endrop_act_cycles", 32'(act_n), 32'd12);
        act_n = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (o_rd_act) act_n++;
        end
        check("endrop_no_reactivate", 32'(act_n), 32'd0);
        check("endrop_buffer_count", o_buffer_count, 32'd1);
        check("endrop_word_count",   o_word_count,   32'd10);
        i_rd_rdy = 1'b0;

        // Reset asserted after 4 pops of a 12-word buffer.
        pulse_clear();
        i_rd_size = SW'(12);
        i_rd_rdy  = 1'b1;
        i_enable  = 1'b1;
        begin
            bit reached;
            reached = 1'b0;
            for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
                @(negedge clk); #1;
                if (m_busy) i_rd_rdy = 1'b0;
                if (m_pop == 4) reached = 1'b1;
            end
            checks++;
            if (!reached) begin
                failures++;
                $display("FAIL rst_mid_timeout got=pops<4 exp=pops=4");
            end
        end
        check("pre_rst_word_count", o_word_count,   32'd4);
        check("pre_rst_act",        32'(o_rd_act),  32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_act",          32'(o_rd_act),  32'd0);
        check("midrst_stb",          32'(o_rd_stb),  32'd0);
        check("midrst_word_count",   o_word_count,   32'd0);
        check("midrst_buffer_count", o_buffer_count, 32'd0);
        check("midrst_error_count",  o_error_count,  32'd0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        run_buf(4, -1, -1, 1'b0, act_n);
        check("restart_word_count",   o_word_count,   32'd4);
        check("restart_buffer_count", o_buffer_count, 32'd1);
        check("restart_error",        32'(o_error),   32'd0);

        // Clear on the same edge as a mismatching pop (word 2 of 8).
        pulse_clear();
        fill(2, 32'h1234_5678);
        run_buf(8, -1, 2, 1'b0, act_n);
        check("clrcol_error",        32'(o_error),   32'd0);
        check("clrcol_error_count",  o_error_count,  32'd0);
        check("clrcol_word_count",   o_word_count,   32'd5);
        check("clrcol_buffer_count", o_buffer_count, 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
